// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : button_event_ctrl
// Purpose  : Press-edge detector for debounced buttons. Holds sticky pending
//            bits and a mask, drives one registered irq line, and provides a
//            single-cycle register port:
//              0 LEVEL (RO), 1 PENDING (W1C), 2 MASK (RW), 3 LONG (W1C).
// Optional : BTN_LONGPRESS_EN enables per-button long-press detection.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_ctrl #(
  parameter int N           = 4,
  parameter int LONG_CYCLES = 1000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] data_i,
  input  logic [1:0]   addr_i,
  input  logic         wr_i,
  input  logic         rd_i,
  input  logic [7:0]   wdata_i,
  output logic [7:0]   rdata_o,
  output logic         irq_o
);

  localparam logic [1:0] ADDR_LEVEL   = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_LONG    = 2'd3;

  logic [N-1:0] s1_q;
  logic [N-1:0] prev_q;
  logic [1:0]   prime_q;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] longpend_q, longpend_d;
  logic [7:0]   rdata_q, rdata_d;
  logic         irq_q, irq_d;

  logic [N-1:0] press;
  logic [N-1:0] clr_pend;
  logic         unused_wdata;

  // Bits of wdata above N-1 have no destination.
  assign unused_wdata = ^wdata_i;

  // prev only holds a genuine sample from the second clock after reset, so
  // press detection waits until then: a button already high when reset
  // releases does not generate an event.
  assign press    = (s1_q & ~prev_q) & {N{prime_q[1]}};
  assign clr_pend = (wr_i && addr_i == ADDR_PENDING) ? wdata_i[N-1:0] : '0;

  // Sticky pending: a press in the same cycle as a W1C wins.
  always_comb begin
    pending_d = (pending_q & ~clr_pend) | press;
  end

  // Mask register write.
  always_comb begin
    mask_d = mask_q;
    if (wr_i && addr_i == ADDR_MASK) begin
      mask_d = wdata_i[N-1:0];
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam int              CW      = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0]   FIRE_AT = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0]   SAT     = CW'(LONG_CYCLES);

  logic [N-1:0] long_fire;
  logic [N-1:0] clr_long;

  assign clr_long = (wr_i && addr_i == ADDR_LONG) ? wdata_i[N-1:0] : '0;

  for (genvar i = 0; i < N; i++) begin : g_long
    logic [CW-1:0] cnt_q;

    // Count consecutive high samples; saturate so the press fires only once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (!s1_q[i]) begin
        cnt_q <= '0;
      end else if (cnt_q != SAT) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign long_fire[i] = s1_q[i] && (cnt_q == FIRE_AT);
  end

  // Sticky long-press pending with the same set-wins rule.
  always_comb begin
    longpend_d = (longpend_q & ~clr_long) | long_fire;
  end
`else
  // Long-press detection not built; register stays at zero.
  always_comb begin
    longpend_d = '0;
  end
`endif

  // Read mux returns pre-write state; rdata holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_i) begin
      rdata_d = 8'h00;
      case (addr_i)
        ADDR_LEVEL:   rdata_d[N-1:0] = s1_q;
        ADDR_PENDING: rdata_d[N-1:0] = pending_q;
        ADDR_MASK:    rdata_d[N-1:0] = mask_q;
        ADDR_LONG:    rdata_d[N-1:0] = longpend_q;
        default:      rdata_d        = 8'h00;
      endcase
    end
  end

  // Interrupt from any unmasked short or long pending source.
  always_comb begin
    irq_d = (|(pending_q & mask_q)) | (|(longpend_q & mask_q));
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q       <= '0;
      prev_q     <= '0;
      prime_q    <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      longpend_q <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      s1_q       <= data_i;
      prev_q     <= s1_q;
      prime_q    <= {prime_q[0], 1'b1};
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      longpend_q <= longpend_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule
`default_nettype wire
